edge_buff_fetch: RTL and testbench
==================================

EDGE_BUFF_FETCH -- requirements
Module: edge_buff_fetch

Interface
REQ-001 Parameter PIX_W, default 8, bits per pixel.
REQ-002 Parameter ADDR_W, default 20, pixel address width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 fill_buff  input  1  level request from edge-detect stage; held high until buff_filled seen.
REQ-006 ED_rpixnum  input  ADDR_W  top-left pixel index of 3x4 window; sampled at request accept.
REQ-007 image_width  input  12  pixels per row; static during operation.
REQ-008 buff_filled  output  1  one-cycle pulse: ED_rdata valid.
REQ-009 ED_rdata  output  12*PIX_W  packed window, pixel k=r*4+c at bits [PIX_W*k+PIX_W-1 : PIX_W*k].
REQ-010 fetch_busy  output  1  high in any state except IDLE.
REQ-011 mem_ren  output  1  one-cycle read strobe.
REQ-012 mem_raddr  output  ADDR_W  read pixel address, valid with mem_ren.
REQ-013 mem_rdata  input  PIX_W  read data, valid with mem_rvalid.
REQ-014 mem_rvalid  input  1  read return; arbitrary latency >=1 cycle; one per mem_ren.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_DATA, DONE, HOLD.
REQ-016 IDLE: fill_buff=1 -> latch base=ED_rpixnum, row=0, col=0, row_base=base; go ISSUE.
REQ-017 ISSUE: mem_ren=1 for exactly one cycle, mem_raddr=row_base+col; go WAIT_DATA.
REQ-018 WAIT_DATA: on mem_rvalid write mem_rdata into assembly slot row*4+col; if last pixel go DONE, else advance and go ISSUE.
REQ-019 Advance order: col 0..3 within row; col wrap -> row+1, row_base+=image_width (adder, no multiplier).
REQ-020 At most one read outstanding; full fetch = 12 reads, min 25 cycles accept-to-buff_filled with 1-cycle memory latency.
REQ-021 Entry to DONE copies assembly register to ED_rdata; ED_rdata otherwise stable, incl. during next fetch.
REQ-022 DONE: buff_filled=1 one cycle; go HOLD.
REQ-023 HOLD: wait fill_buff=0 then IDLE; prevents double-accept of a lingering request.
REQ-024 fill_buff falling mid-fetch: finish outstanding read, discard, go IDLE without buff_filled; ED_rdata unchanged.
REQ-025 mem_rvalid outside WAIT_DATA ignored.
REQ-026 Address arithmetic ADDR_W bits, wraps modulo 2^ADDR_W; no bounds check.

Reset
REQ-027 n_rst low: state IDLE, ED_rdata=0, assembly=0, buff_filled=0, mem_ren=0, mem_raddr=0, fetch_busy=0, counters 0.
REQ-028 Reset mid-fetch aborts immediately; late mem_rvalid after release ignored in IDLE.

Configuration
REQ-029 Macro EDGE_BUFF_COLSHIFT_EN defined: if previous fetch completed and new base == previous base+2, shift each row left two pixels (old cols 2,3 -> cols 0,1) and fetch only cols 2,3 of each row (6 reads).
REQ-030 Macro undefined: every request fetches all 12 pixels; no previous-base register exists.
REQ-031 Aborted fetch or reset clears shift eligibility.

Structure
REQ-032 Package edge_pkg: state enum, PIX_W/ADDR_W defaults, WIN_ROWS=3, WIN_COLS=4.
REQ-033 One sub-module edge_win_addr: row/col counters and row_base accumulator, outputs address and last flag.

Verification
REQ-034 width=8, base=0, mem[i]=i, latency 1 -> reads addr 0,1,2,3,8,9,10,11,16,17,18,19; ED_rdata bytes 0..11 = those values; buff_filled at cycle 25.
REQ-035 Random mem_rvalid latency 1..5 -> same ED_rdata; never two reads outstanding.
REQ-036 fill_buff held high 3 cycles after buff_filled -> exactly one fetch, HOLD until release.
REQ-037 fill_buff dropped after 5th read -> no buff_filled, ED_rdata equals prior window, IDLE after return.
REQ-038 n_rst pulsed mid-fetch -> all outputs zero next edge; next request fetches full 12.
REQ-039 COLSHIFT_EN, base 0 then base 2 -> second fetch reads 4,5,12,13,20,21 only; ED_rdata equals full fetch at base 2.

Source files
------------

// File: rtl/edge_buff_fetch_pkg.sv
// Shared state encoding and window geometry for the edge-detect window fetcher.
package edge_pkg;
    localparam int DEF_PIX_W  = 8;
    localparam int DEF_ADDR_W = 20;
    localparam int WIN_ROWS   = 3;
    localparam int WIN_COLS   = 4;
    localparam int WIN_PIX    = WIN_ROWS * WIN_COLS;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, DONE, HOLD} state_t;
endpackage

// File: rtl/edge_buff_fetch_if.sv
// Single-outstanding pixel read bus between the window fetcher and pixel memory.
interface edge_buff_fetch_if
    import edge_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [PIX_W-1:0]  mem_rdata;
    logic              mem_rvalid;

    modport master (output mem_ren, mem_raddr, input mem_rdata, mem_rvalid);
    modport slave  (input mem_ren, mem_raddr, output mem_rdata, mem_rvalid);
endinterface

// File: rtl/edge_buff_fetch_win_addr.sv
// Window walker: row/col counters plus a row_base accumulator stepped by image_width.
module edge_win_addr
    import edge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [1:0]        col_start,
    input  logic [11:0]       image_width,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        row,
    output logic [1:0]        col,
    output logic              last
);
    logic [ADDR_W-1:0] row_base;
    logic [1:0]        col_first;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row       <= '0;
            col       <= '0;
            col_first <= '0;
            row_base  <= '0;
        end else if (start) begin
            row       <= '0;
            col       <= col_start;
            col_first <= col_start;
            row_base  <= base;
        end else if (step) begin
            // Row wrap restarts at the first fetched column, not always column 0.
            if (col == 2'(WIN_COLS - 1)) begin
                col      <= col_first;
                row      <= row + 2'd1;
                row_base <= row_base + ADDR_W'(image_width);
            end else begin
                col <= col + 2'd1;
            end
        end
    end

    assign addr = row_base + ADDR_W'(col);
    assign last = (row == 2'(WIN_ROWS - 1)) && (col == 2'(WIN_COLS - 1));
endmodule

// File: rtl/edge_buff_fetch.sv
// Edge-detect window fetcher: gathers a 3x4 pixel window one memory read at a time.
// Define EDGE_BUFF_COLSHIFT_EN to reuse the right half of the last window on a +2 step.
module edge_buff_fetch
    import edge_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     fill_buff,
    input  logic [ADDR_W-1:0]        ED_rpixnum,
    input  logic [11:0]              image_width,
    output logic                     buff_filled,
    output logic [WIN_PIX*PIX_W-1:0] ED_rdata,
    output logic                     fetch_busy,
    edge_buff_fetch_if.master        mem
);
    state_t                   state, state_nx;
    logic [WIN_PIX*PIX_W-1:0] asm_q, asm_wr;
    logic [1:0]               row, col;
    logic [ADDR_W-1:0]        addr;
    logic                     last, start, step, wr, capture, drop, abort_q, shift_hit;

    edge_win_addr #(.ADDR_W(ADDR_W)) u_addr (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .step        (step),
        .base        (ED_rpixnum),
        .col_start   (shift_hit ? 2'd2 : 2'd0),
        .image_width (image_width),
        .addr        (addr),
        .row         (row),
        .col         (col),
        .last        (last)
    );

    assign mem.mem_ren   = (state == ISSUE);
    assign mem.mem_raddr = addr;
    assign buff_filled   = (state == DONE);
    assign fetch_busy    = (state != IDLE);

    // A dropped request still waits for its outstanding read before leaving.
    assign start   = (state == IDLE) && fill_buff;
    assign drop    = (state == WAIT_DATA) && mem.mem_rvalid && (abort_q || !fill_buff);
    assign wr      = (state == WAIT_DATA) && mem.mem_rvalid && !drop;
    assign capture = wr && last;
    assign step    = wr && !last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (fill_buff) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_DATA;
            WAIT_DATA: begin
                if (drop)         state_nx = IDLE;
                else if (capture) state_nx = DONE;
                else if (step)    state_nx = ISSUE;
            end
            DONE:      state_nx = HOLD;
            HOLD:      if (!fill_buff) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                                                    abort_q <= 1'b0;
        else if (start)                                                abort_q <= 1'b0;
        else if ((state == ISSUE || state == WAIT_DATA) && !fill_buff) abort_q <= 1'b1;
    end

    always_comb begin
        asm_wr = asm_q;
        asm_wr[int'({row, col})*PIX_W +: PIX_W] = mem.mem_rdata;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            asm_q    <= '0;
            ED_rdata <= '0;
        end else begin
            if (start && shift_hit) begin
                for (int r = 0; r < WIN_ROWS; r++)
                    asm_q[r*WIN_COLS*PIX_W +: 2*PIX_W] <= ED_rdata[(r*WIN_COLS+2)*PIX_W +: 2*PIX_W];
            end else if (wr) begin
                asm_q <= asm_wr;
            end
            if (capture) ED_rdata <= asm_wr;
        end
    end

`ifdef EDGE_BUFF_COLSHIFT_EN
    logic [ADDR_W-1:0] base_q;
    logic              shift_ok;

    // Only a window that completed is trusted as the source of reused columns.
    assign shift_hit = shift_ok && (ED_rpixnum == base_q + ADDR_W'(2));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            base_q   <= '0;
            shift_ok <= 1'b0;
        end else begin
            if (start)        base_q   <= ED_rpixnum;
            if (capture)      shift_ok <= 1'b1;
            else if (drop)    shift_ok <= 1'b0;
        end
    end
`else
    assign shift_hit = 1'b0;
`endif
endmodule

// File: tb/tb_edge_buff_fetch.sv
// Randomized self-checking bench for edge_buff_fetch against a window-level reference model.
`timescale 1ns/1ps
module tb_edge_buff_fetch;
    localparam int PW = 8;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          fill_buff = 1'b0;
    logic [AW-1:0] ED_rpixnum = '0;
    logic [11:0]   image_width = 12'd8;
    logic          buff_filled, fetch_busy;
    logic [12*PW-1:0] ED_rdata;

    edge_buff_fetch_if #(.PIX_W(PW), .ADDR_W(AW)) mem ();

    edge_buff_fetch #(.PIX_W(PW), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .fill_buff(fill_buff), .ED_rpixnum(ED_rpixnum),
        .image_width(image_width), .buff_filled(buff_filled), .ED_rdata(ED_rdata),
        .fetch_busy(fetch_busy), .mem(mem)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int lat_lo = 1, lat_hi = 1, cnt = 0, overlap = 0, bf_cnt = 0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] exp_q[$];

    // reference model state
    bit              m_ok = 1'b0;
    logic [AW-1:0]   m_prev = '0;
    logic [12*PW-1:0] m_win = '0;

    function automatic logic [PW-1:0] mval(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
    endfunction

    function automatic logic [12*PW-1:0] win(input logic [AW-1:0] b, input logic [11:0] w);
        logic [12*PW-1:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                v[(r*4+c)*PW +: PW] = mval(b + AW'(r) * AW'(w) + AW'(c));
        return v;
    endfunction

    function automatic bit exp_shift(input logic [AW-1:0] b);
`ifdef EDGE_BUFF_COLSHIFT_EN
        return m_ok && (b == m_prev + AW'(2));
`else
        return 1'b0;
`endif
    endfunction

    function automatic void build_exp(input logic [AW-1:0] b, input logic [11:0] w, input bit sh);
        exp_q.delete();
        for (int r = 0; r < 3; r++)
            for (int c = (sh ? 2 : 0); c < 4; c++)
                exp_q.push_back(b + AW'(r) * AW'(w) + AW'(c));
    endfunction

    function automatic bit reads_ok();
        if (rd_log.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (rd_log[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_done(input logic [AW-1:0] b);
        m_ok = 1'b1;
        m_prev = b;
        m_win = win(b, image_width);
    endfunction

    // memory responder: one read per strobe, latency lat_lo..lat_hi cycles
    initial begin
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem.mem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata  = mval(pend_addr);
                end
            end
            if (mem.mem_ren === 1'b1) begin
                if (cnt != 0 || mem.mem_rvalid) overlap++;
                pend_addr = mem.mem_raddr;
                rd_log.push_back(mem.mem_raddr);
                cnt = $urandom_range(lat_hi, lat_lo);
            end
            if (buff_filled === 1'b1) bf_cnt++;
        end
    end

    task automatic run_fetch(input logic [AW-1:0] b, output int cyc);
        rd_log.delete();
        @(negedge clk);
        ED_rpixnum = b;
        fill_buff  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (buff_filled !== 1'b1 && cyc < 2000);
    endtask

    task automatic release_req();
        fill_buff = 1'b0;
        for (int i = 0; i < 50 && fetch_busy !== 1'b0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        fill_buff = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (buff_filled !== 1'b0) begin errors++; $display("FAIL reset_buff_filled got=%b exp=0", buff_filled); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", fetch_busy); end
        checks++; if (mem.mem_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got=%b exp=0", mem.mem_ren); end
        checks++; if (mem.mem_raddr !== '0) begin errors++; $display("FAIL reset_raddr got=%h exp=0", mem.mem_raddr); end
        checks++; if (ED_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", ED_rdata); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", fetch_busy); end
    endtask

    task automatic test_basic();
        int cyc, bf0;
        logic [AW-1:0] b;
        image_width = 12'd8; lat_lo = 1; lat_hi = 1; overlap = 0; bf0 = bf_cnt;
        build_exp(20'd0, image_width, exp_shift(20'd0));
        run_fetch(20'd0, cyc);
        checks++; if (cyc != 25) begin errors++; $display("FAIL basic_latency got=%0d exp=25", cyc); end
        checks++; if (!reads_ok()) begin errors++; $display("FAIL basic_reads got_n=%0d exp_n=%0d", rd_log.size(), exp_q.size()); end
        checks++; if (ED_rdata !== 96'h13121110_0b0a0908_03020100) begin errors++; $display("FAIL basic_rdata got=%h exp=%h", ED_rdata, 96'h13121110_0b0a0908_03020100); end
        model_done(20'd0);
        release_req();
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL basic_idle got=%b exp=0", fetch_busy); end
        checks++; if (bf_cnt - bf0 != 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", bf_cnt - bf0); end
        // address wrap at the top of the address space
        b = 20'hFFFFD;
        build_exp(b, image_width, exp_shift(b));
        run_fetch(b, cyc);
        checks++; if (!reads_ok()) begin errors++; $display("FAIL wrap_reads got_n=%0d exp_n=%0d", rd_log.size(), exp_q.size()); end
        checks++; if (ED_rdata !== win(b, image_width)) begin errors++; $display("FAIL wrap_rdata got=%h exp=%h", ED_rdata, win(b, image_width)); end
        model_done(b);
        release_req();
        checks++; if (overlap != 0) begin errors++; $display("FAIL basic_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_colshift();
        int cyc;
        logic [AW-1:0] b;
        image_width = 12'd8; lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 3; i++) begin
            b = AW'(2 * i);
            build_exp(b, image_width, exp_shift(b));
            run_fetch(b, cyc);
            checks++; if (!reads_ok()) begin errors++; $display("FAIL colshift_reads[%0d] got_n=%0d exp_n=%0d", i, rd_log.size(), exp_q.size()); end
            checks++; if (cyc != 2 * exp_q.size() + 1) begin errors++; $display("FAIL colshift_latency[%0d] got=%0d exp=%0d", i, cyc, 2 * exp_q.size() + 1); end
            checks++; if (ED_rdata !== win(b, image_width)) begin errors++; $display("FAIL colshift_rdata[%0d] got=%h exp=%h", i, ED_rdata, win(b, image_width)); end
`ifdef EDGE_BUFF_COLSHIFT_EN
            if (i == 1) begin
                checks++;
                if (rd_log.size() != 6 || rd_log[0] !== 20'd4 || rd_log[1] !== 20'd5 || rd_log[2] !== 20'd12 ||
                    rd_log[3] !== 20'd13 || rd_log[4] !== 20'd20 || rd_log[5] !== 20'd21) begin
                    errors++; $display("FAIL colshift_addr_list got_n=%0d exp=4,5,12,13,20,21", rd_log.size());
                end
            end
`endif
            model_done(b);
            release_req();
        end
    endtask

    task automatic test_hold();
        int cyc, bf0, n;
        bf0 = bf_cnt; lat_lo = 1; lat_hi = 2;
        build_exp(20'd100, image_width, exp_shift(20'd100));
        run_fetch(20'd100, cyc);
        n = rd_log.size();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (fetch_busy !== 1'b1 || buff_filled !== 1'b0) begin errors++; $display("FAIL hold_state[%0d] got busy=%b filled=%b exp busy=1 filled=0", i, fetch_busy, buff_filled); end
        end
        release_req();
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", fetch_busy); end
        checks++; if (bf_cnt - bf0 != 1 || rd_log.size() != n) begin errors++; $display("FAIL hold_single got pulses=%0d reads=%0d exp pulses=1 reads=%0d", bf_cnt - bf0, rd_log.size(), n); end
        checks++; if (!reads_ok()) begin errors++; $display("FAIL hold_reads got_n=%0d exp_n=%0d", rd_log.size(), exp_q.size()); end
        checks++; if (ED_rdata !== win(20'd100, image_width)) begin errors++; $display("FAIL hold_rdata got=%h exp=%h", ED_rdata, win(20'd100, image_width)); end
        model_done(20'd100);
    endtask

    task automatic test_random();
        int cyc;
        logic [AW-1:0] b;
        lat_lo = 1; lat_hi = 5; overlap = 0;
        image_width = 12'($urandom_range(4095, 4));
        for (int i = 0; i < 10; i++) begin
            b = (i > 0 && $urandom_range(1, 0) == 1) ? m_prev + AW'(2) : AW'($urandom);
            build_exp(b, image_width, exp_shift(b));
            run_fetch(b, cyc);
            checks++; if (buff_filled !== 1'b1) begin errors++; $display("FAIL rand_filled[%0d] got=%b exp=1 after %0d cycles", i, buff_filled, cyc); end
            checks++; if (!reads_ok()) begin errors++; $display("FAIL rand_reads[%0d] got_n=%0d exp_n=%0d", i, rd_log.size(), exp_q.size()); end
            checks++; if (ED_rdata !== win(b, image_width)) begin errors++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, ED_rdata, win(b, image_width)); end
            model_done(b);
            repeat ($urandom_range(2, 0)) @(negedge clk);
            release_req();
        end
        checks++; if (overlap != 0) begin errors++; $display("FAIL rand_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_abort();
        int cyc, bf0, k;
        logic [AW-1:0] b;
        logic [12*PW-1:0] prior;
        prior = m_win; bf0 = bf_cnt; lat_lo = 1; lat_hi = 3;
        b = m_prev + AW'(2);
        rd_log.delete();
        @(negedge clk);
        ED_rpixnum = b;
        fill_buff = 1'b1;
        k = 0;
        while (rd_log.size() < 5 && k < 500) begin @(posedge clk); #2; k++; end
        fill_buff = 1'b0;
        k = 0;
        while (fetch_busy !== 1'b0 && k < 50) begin @(negedge clk); k++; end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", fetch_busy); end
        checks++; if (rd_log.size() != 5) begin errors++; $display("FAIL abort_reads got=%0d exp=5", rd_log.size()); end
        checks++; if (bf_cnt != bf0) begin errors++; $display("FAIL abort_no_pulse got=%0d exp=0", bf_cnt - bf0); end
        checks++; if (ED_rdata !== prior) begin errors++; $display("FAIL abort_rdata got=%h exp=%h", ED_rdata, prior); end
        m_ok = 1'b0;
        repeat (3) @(negedge clk);
        build_exp(b, image_width, exp_shift(b));
        run_fetch(b, cyc);
        checks++; if (!reads_ok()) begin errors++; $display("FAIL abort_refetch_reads got_n=%0d exp_n=%0d", rd_log.size(), exp_q.size()); end
        checks++; if (ED_rdata !== win(b, image_width)) begin errors++; $display("FAIL abort_refetch_rdata got=%h exp=%h", ED_rdata, win(b, image_width)); end
        model_done(b);
        release_req();
    endtask

    task automatic test_reset_mid();
        int cyc, k;
        logic [AW-1:0] b;
        lat_lo = 4; lat_hi = 4;
        rd_log.delete();
        @(negedge clk);
        ED_rpixnum = m_prev + AW'(2);
        fill_buff = 1'b1;
        k = 0;
        while (rd_log.size() < 3 && k < 500) begin @(posedge clk); #2; k++; end
        n_rst = 1'b0;
        #1;
        checks++; if (fetch_busy !== 1'b0 || buff_filled !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got busy=%b filled=%b exp 0 0", fetch_busy, buff_filled); end
        checks++; if (mem.mem_ren !== 1'b0 || mem.mem_raddr !== '0) begin errors++; $display("FAIL rstmid_bus got ren=%b addr=%h exp 0 0", mem.mem_ren, mem.mem_raddr); end
        checks++; if (ED_rdata !== '0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", ED_rdata); end
        fill_buff = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        m_ok = 1'b0;
        m_win = '0;
        repeat (10) @(negedge clk);
        checks++; if (fetch_busy !== 1'b0 || ED_rdata !== '0) begin errors++; $display("FAIL rstmid_late_rvalid got busy=%b rdata=%h exp 0 0", fetch_busy, ED_rdata); end
        lat_lo = 1; lat_hi = 1;
        b = m_prev + AW'(2);
        build_exp(b, image_width, exp_shift(b));
        run_fetch(b, cyc);
        checks++; if (rd_log.size() != 12 || !reads_ok()) begin errors++; $display("FAIL rstmid_refetch_reads got_n=%0d exp_n=12", rd_log.size()); end
        checks++; if (ED_rdata !== win(b, image_width)) begin errors++; $display("FAIL rstmid_refetch_rdata got=%h exp=%h", ED_rdata, win(b, image_width)); end
        model_done(b);
        release_req();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_colshift();
        test_hold();
        test_random();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
